mmem_arbiter: RTL and testbench

Shares the single main-memory port between the instruction-fetch requester and the data-access requester of the decode/execute stage. Each requester issues a one-access-at-a-time request/done handshake. The arbiter selects one winner, sequences the memory's separate read and write address ports, waits out the memory read latency and returns registered read data. It sits between the fetch/decode control and the main memory.

---
 rtl/mmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mmem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmem_arbiter.sv
// mmem_arbiter: shares the main-memory port between fetch and data access.
// Define MMEM_ARB_RR_EN for round-robin grants; default is dm over if.
module mmem_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              win_dm_q, win_dm_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic              grant_dm;

`ifdef MMEM_ARB_RR_EN
    // Pointer holds the last granted port (1 = dm); contention goes to the other.
    logic ptr_dm_q, ptr_dm_d;

    always_comb begin
        grant_dm = dm_req;
        if (if_req && dm_req) begin
            grant_dm = ~ptr_dm_q;
        end
    end
`else
    always_comb begin
        grant_dm = dm_req;
    end
`endif

    always_comb begin
        state_d    = state_q;
        win_dm_d   = win_dm_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        raddr_d    = raddr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wren_d     = 1'b0;
`ifdef MMEM_ARB_RR_EN
        ptr_dm_d   = ptr_dm_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (if_req || dm_req) begin
                    win_dm_d = grant_dm;
                    we_d     = grant_dm & dm_we;
`ifdef MMEM_ARB_RR_EN
                    ptr_dm_d = grant_dm;
`endif
                    // Memory address/data registers double as the request latch.
                    if (grant_dm && dm_we) begin
                        waddr_d = dm_addr;
                        wdata_d = dm_wdata;
                        wren_d  = 1'b1;
                    end else if (grant_dm) begin
                        raddr_d = dm_addr;
                    end else begin
                        raddr_d = if_addr;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    dm_done_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    if (win_dm_q) begin
                        dm_rdata_d = mem_rdata;
                        dm_done_d  = 1'b1;
                    end else begin
                        if_rdata_d = mem_rdata;
                        if_done_d  = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_dm_q   <= 1'b0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            raddr_q    <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wren_q     <= 1'b0;
`ifdef MMEM_ARB_RR_EN
            ptr_dm_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_dm_q   <= win_dm_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            raddr_q    <= raddr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wren_q     <= wren_d;
`ifdef MMEM_ARB_RR_EN
            ptr_dm_q   <= ptr_dm_d;
`endif
        end
    end

    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_done   = if_done_q;
    assign dm_done   = dm_done_q;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign mem_wren  = wren_q;

endmodule

// File: tb/tb_mmem_arbiter.sv
// Bench for mmem_arbiter: transaction-timing model plus directed vectors.
// Second instance exercises RD_LAT=3 with a bench-driven read bus.
module tb_mmem_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [16:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [16:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [16:0] mem_raddr, mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wren;
    logic [31:0] mem_rdata;

    logic        if_req3 = 1'b0;
    logic [16:0] if_addr3 = '0;
    logic [31:0] if_rdata3, dm_rdata3;
    logic        if_done3, dm_done3;
    logic [16:0] mem_raddr3, mem_waddr3;
    logic [31:0] mem_wdata3;
    logic        mem_wren3;
    logic [31:0] mem_rdata3 = '0;

    int total = 0;
    int passed = 0;
    int cyc = 0;

    mmem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(RD_LAT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_wren(mem_wren),
        .mem_rdata(mem_rdata)
    );

    mmem_arbiter #(.ADDR_W(17), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(if_req3), .if_addr(if_addr3),
        .if_rdata(if_rdata3), .if_done(if_done3),
        .dm_req(1'b0), .dm_we(1'b0), .dm_addr(17'h0),
        .dm_wdata(32'h0), .dm_rdata(dm_rdata3), .dm_done(dm_done3),
        .mem_raddr(mem_raddr3), .mem_waddr(mem_waddr3),
        .mem_wdata(mem_wdata3), .mem_wren(mem_wren3),
        .mem_rdata(mem_rdata3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Environment memory with one-cycle read latency.
    logic [31:0] emem [0:131071];
    always @(posedge clk) begin
        mem_rdata <= emem[mem_raddr];
        if (mem_wren) emem[mem_waddr] <= mem_wdata;
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    endtask

    // Transaction model: one grant per free IDLE cycle, fixed latencies.
    logic [31:0] mmem [int];
    bit          mv = 0;
    bit          rst_pend = 0;
    bit          act = 0;
    bit          fin;
    bit          ptr_dm = 1;
    bit          g_dm;
    bit          t_dm, t_we;
    int          t_s, t_dn;
    logic [16:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] e_if_rd, e_dm_rd, e_wdata;
    logic [16:0] e_raddr, e_waddr;
    bit          e_wren, e_ifd, e_dmd;

    function automatic logic [31:0] rd(input logic [16:0] a);
        return mmem.exists(int'(a)) ? mmem[int'(a)] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (rst_pend) begin
            e_if_rd = '0; e_dm_rd = '0; e_wdata = '0;
            e_raddr = '0; e_waddr = '0;
            act = 0; ptr_dm = 1; mv = 1; rst_pend = 0;
        end
        e_wren = 0; e_ifd = 0; e_dmd = 0; fin = 0;
        if (act) begin
            if (cyc == t_s + 1) begin
                if (t_we) begin
                    e_waddr = t_addr; e_wdata = t_wdata; e_wren = 1;
                end else begin
                    e_raddr = t_addr;
                end
            end
            if (cyc == t_dn) begin
                fin = 1;
                if (t_dm) e_dmd = 1; else e_ifd = 1;
                if (!t_we && t_dm) e_dm_rd = rd(t_addr);
                if (!t_we && !t_dm) e_if_rd = rd(t_addr);
            end
        end
        if (mv) begin
            chk("if_done", 32'(if_done), 32'(e_ifd));
            chk("dm_done", 32'(dm_done), 32'(e_dmd));
            chk("mem_wren", 32'(mem_wren), 32'(e_wren));
            chk("if_rdata", if_rdata, e_if_rd);
            chk("dm_rdata", dm_rdata, e_dm_rd);
            chk("mem_raddr", 32'(mem_raddr), 32'(e_raddr));
            chk("mem_waddr", 32'(mem_waddr), 32'(e_waddr));
            chk("mem_wdata", mem_wdata, e_wdata);
        end
        if (act && t_we && cyc == t_s + 1) mmem[int'(t_addr)] = t_wdata;
        if (rst) begin
            rst_pend = 1;
        end else if (mv && !act && (if_req || dm_req)) begin
`ifdef MMEM_ARB_RR_EN
            g_dm = (if_req && dm_req) ? !ptr_dm : dm_req;
            ptr_dm = g_dm;
`else
            g_dm = dm_req;
`endif
            t_dm    = g_dm;
            t_we    = g_dm && dm_we;
            t_addr  = g_dm ? dm_addr : if_addr;
            t_wdata = dm_wdata;
            t_s     = cyc;
            t_dn    = t_we ? cyc + 2 : cyc + 2 + RD_LAT;
            act     = 1;
        end
        if (fin) act = 0;
    end

    task automatic do_if(input logic [16:0] a, output int lat,
                         output logic [31:0] d);
        @(posedge clk); #1;
        if_req = 1; if_addr = a; lat = -1; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (if_done) begin lat = k; d = if_rdata; break; end
        end
        if_req = 0;
        if (lat < 0) begin
            total++;
            $display("FAIL if_timeout: got no if_done want done by 40");
        end
    endtask

    task automatic do_dm(input logic we, input logic [16:0] a,
                         input logic [31:0] wd, output int lat,
                         output logic [31:0] d);
        @(posedge clk); #1;
        dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd;
        lat = -1; d = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (dm_done) begin lat = k; d = dm_rdata; break; end
        end
        dm_req = 0;
        if (lat < 0) begin
            total++;
            $display("FAIL dm_timeout: got no dm_done want done by 40");
        end
    endtask

    int          l_if, l_dm, x_if, x_dm;
    logic [31:0] d_if, d_dm;

    initial begin
        for (int i = 0; i < 131072; i++) emem[i] = '0;
        emem[17'h00010] = 32'h12345678;
        emem[17'h00020] = 32'hA5A50020;
        mmem[32'h10] = 32'h12345678;
        mmem[32'h20] = 32'hA5A50020;

        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_mem_raddr", 32'(mem_raddr), 32'h0);

        do_if(17'h00010, l_if, d_if);
        chk("fetch_lat", l_if, 3);
        chk("fetch_data", d_if, 32'h12345678);
        chk("fetch_raddr", 32'(mem_raddr), 32'h00010);

        do_dm(1'b1, 17'h1FFFF, 32'hDEADBEEF, l_dm, d_dm);
        chk("write_lat", l_dm, 2);
        chk("write_waddr", 32'(mem_waddr), 32'h1FFFF);
        chk("write_dm_rdata", dm_rdata, 32'h0);

        do_dm(1'b0, 17'h1FFFF, 32'h0, l_dm, d_dm);
        chk("read_lat", l_dm, 3);
        chk("read_data", d_dm, 32'hDEADBEEF);
        chk("read_if_hold", if_rdata, 32'h12345678);

`ifdef MMEM_ARB_RR_EN
        x_if = 3; x_dm = 7;
`else
        x_if = 7; x_dm = 3;
`endif
        for (int r = 0; r < 2; r++) begin
            fork
                do_if(17'h00020, l_if, d_if);
                do_dm(1'b0, 17'h1FFFF, 32'h0, l_dm, d_dm);
            join
            chk("cont_if_lat", l_if, x_if);
            chk("cont_dm_lat", l_dm, x_dm);
            chk("cont_if_data", d_if, 32'hA5A50020);
            chk("cont_dm_data", d_dm, 32'hDEADBEEF);
        end

        @(posedge clk); #1;
        dm_req = 1; dm_we = 1; dm_addr = 17'h00055; dm_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        chk("rmw_wren_on", 32'(mem_wren), 32'h1);
        rst = 1; dm_req = 0;
        @(posedge clk); #1;
        rst = 0;
        chk("rmw_wren_off", 32'(mem_wren), 32'h0);
        chk("rmw_no_done", 32'(dm_done), 32'h0);
        chk("rmw_if_rdata", if_rdata, 32'h0);
        chk("rmw_dm_rdata", dm_rdata, 32'h0);
        chk("rmw_waddr", 32'(mem_waddr), 32'h0);
        chk("rmw_wdata", mem_wdata, 32'h0);
        @(posedge clk); #1;
        chk("rmw_no_done2", 32'(dm_done), 32'h0);

        do_if(17'h00010, l_if, d_if);
        chk("post_rst_lat", l_if, 3);
        chk("post_rst_data", d_if, 32'h12345678);

        @(posedge clk); #1;
        if_req3 = 1; if_addr3 = 17'h00123;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            mem_rdata3 = (k == 4) ? 32'hCAFEF00D : (32'hBAD00000 | 32'(k));
            if (k == 1) chk("lat3_raddr", 32'(mem_raddr3), 32'h00123);
            chk("lat3_done", 32'(if_done3), 32'(k == 5));
            chk("lat3_rdata", if_rdata3,
                (k >= 5) ? 32'hCAFEF00D : 32'h0);
            chk("lat3_dm_done", 32'(dm_done3), 32'h0);
            if (k == 5) if_req3 = 0;
        end

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
